// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, sample points and baud divider helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    // Truncated clocks-per-oversample-tick, never below 1 so the divider always ticks.
    function automatic int calc_div(input int clk_freq, input int baud);
        int q;
        q = clk_freq / (baud * OVERSAMPLE);
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, held at zero while clr is high
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clr && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_phy.sv
// rtl/uart_rx_phy.sv - 8N1 UART receiver, 16x oversampled, 3-sample majority vote
module uart_rx_phy #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err
);
    import uart_pkg::*;

    localparam logic [3:0] TC_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TC_LO   = 4'(SAMPLE_LO);
    localparam logic [3:0] TC_MID  = 4'(SAMPLE_MID);
    localparam logic [3:0] TC_HI   = 4'(SAMPLE_HI);

    rx_state_t  r_state;
    rx_state_t  w_next;
    logic       r_rx_m;
    logic       r_rx_s;
    logic [3:0] r_tcnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic       r_smp_lo;
    logic       r_smp_mid;
    logic [7:0] r_data;
    logic       r_ready;
    logic       r_ferr;
    logic       w_clr;
    logic       w_tick;
    logic       w_decide;
    logic       w_vote;
    logic       w_ready_set;
    logic       w_ferr_set;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick)
    );

    assign w_clr    = (r_state == ST_IDLE) || (r_state == ST_WAIT_HIGH);
    assign w_decide = w_tick && (r_tcnt == TC_HI);
    // Third sample is the live synchronised line at the decision tick.
    assign w_vote   = (r_smp_lo & r_smp_mid) | (r_smp_lo & r_rx_s) | (r_smp_mid & r_rx_s);

    always_comb begin
        w_next      = r_state;
        w_ready_set = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) w_next = ST_START;
            end
            ST_START: begin
                if (w_decide) w_next = w_vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_decide && (r_bit_idx == 3'd7)) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_decide) begin
                    w_ready_set = w_vote;
                    w_ferr_set  = !w_vote;
                    w_next      = w_vote ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (r_rx_s) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rx_m    <= 1'b1;
            r_rx_s    <= 1'b1;
            r_tcnt    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_smp_lo  <= 1'b0;
            r_smp_mid <= 1'b0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rx_m  <= rx;
            r_rx_s  <= r_rx_m;
            if (w_clr) begin
                r_tcnt <= '0;
            end else if (w_tick) begin
                r_tcnt <= (r_tcnt == TC_LAST) ? 4'd0 : r_tcnt + 4'd1;
            end
            if (w_tick && (r_tcnt == TC_LO))  r_smp_lo  <= r_rx_s;
            if (w_tick && (r_tcnt == TC_MID)) r_smp_mid <= r_rx_s;
            if (w_decide && (r_state == ST_START)) r_bit_idx <= '0;
            if (w_decide && (r_state == ST_DATA)) begin
                r_shift   <= {w_vote, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_ready_set) r_data <= r_shift;
            r_ready <= w_ready_set;
            r_ferr  <= w_ferr_set;
        end
    end

    assign rx_data   = r_data;
    assign rx_ready  = r_ready;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx_phy.sv
// tb/tb_uart_rx_phy.sv - scoreboard bench for uart_rx_phy at one bit per 16 clk
module tb_uart_rx_phy;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] model_data = 8'h00;

    uart_rx_phy #(
        .CLK_FREQ  (1_843_200),
        .BAUD_RATE (115_200),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    // glitch: position 1..16 within the bit where the line is inverted for one clk, 0 for none
    task automatic send_bit(input logic v, input int glitch);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            rx = (c == glitch) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit, input int gpos);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(b[i], (i == gbit) ? gpos : 0);
        send_bit(stop, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic expect_ready(input logic [7:0] b);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = b;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [7:0] held);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = held;
        exp_q.push_back(e);
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            model_data = 8'h00;
            check("pulse_in_reset", {6'd0, rx_ready, frame_err}, 8'h00);
        end else if (rx_ready && frame_err) begin
            check("ready_and_err_together", 8'h01, 8'h00);
        end else if (rx_ready || frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {6'd0, rx_ready, frame_err}, 8'h00);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_is_err", {7'd0, frame_err}, {7'd0, e.is_err});
                check(e.is_err ? "data_held_on_err" : "rx_data", rx_data, e.data);
                if (!e.is_err) model_data = e.data;
            end
        end else if (rx_data !== model_data) begin
            check("rx_data_stable", rx_data, model_data);
        end
    end

    initial begin
        int waited;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_ready", {7'd0, rx_ready}, 8'h00);
        check("reset_frame_err", {7'd0, frame_err}, 8'h00);
        rst = 1'b0;
        idle(20);

        expect_ready(8'hA5);
        send_frame(8'hA5, 1'b1, -1, 0);
        idle(40);

        expect_ready(8'h41);
        expect_ready(8'h42);
        expect_ready(8'h43);
        send_frame(8'h41, 1'b1, -1, 0);
        send_frame(8'h42, 1'b1, -1, 0);
        send_frame(8'h43, 1'b1, -1, 0);
        idle(40);

        repeat (3) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(60);

        expect_err(8'h43);
        send_frame(8'h3C, 1'b0, -1, 0);
        repeat (40 * 16) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(32);
        expect_ready(8'h7E);
        send_frame(8'h7E, 1'b1, -1, 0);
        idle(40);

        expect_ready(8'h00);
        send_frame(8'h00, 1'b1, 3, 10);
        idle(40);

        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        idle(64);
        check("rx_data_after_mid_frame_rst", rx_data, 8'h00);

        expect_ready(8'hFF);
        send_frame(8'hFF, 1'b1, -1, 0);
        idle(40);

        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("pending_expectations", 8'(exp_q.size()), 8'h00);
        check("final_rx_data", rx_data, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
